// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Hazard unit for a five-stage in-order pipeline with operand forwarding,
// load-use stalls and taken-branch redirects.
//
// The unit keeps its own shadow copy of the EXE and MEM stage destination
// information. ID-stage source operands are compared against that copy to
// choose forwarding paths and to detect load-use hazards.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   id_valid          : ID stage holds a real instruction
//   id_rs, id_rt      : ID source register fields
//   id_use_rs/rt      : ID instruction actually reads rs / rt
//   id_wreg, id_m2reg : ID instruction writes a register / is a load
//   id_destReg        : ID destination register
//   exe_taken         : branch in EXE resolved taken this cycle
//   pc_we, ifid_we    : PC and IF/ID write enables (low = hold)
//   ifid_flush        : load a NOP into IF/ID
//   idexe_bubble      : force ID/EXE wreg/m2reg/wmem to 0
//   fwda, fwdb        : operand source, 00 regfile, 01 EXE r, 10 MEM r,
//                       11 MEM load data
//   state             : 00 RUN, 01 STALL, 10 REDIRECT (registered)
//   stall_cnt         : saturating count of non-RUN cycles
//
// Configuration
//   HAZARD_STALL_CNT_EN : when defined, stall_cnt is a live saturating
//                         counter; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_destReg,
  input  logic             exe_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_REDIRECT = 2'b10
  } state_e;

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic       m2reg;
    logic [4:0] dest;
  } trk_t;

  localparam trk_t TRK_EMPTY = '{valid: 1'b0, wreg: 1'b0, m2reg: 1'b0, dest: 5'd0};

  trk_t   exe_d, exe_q;
  trk_t   mem_d, mem_q;
  state_e state_d, state_q;
  logic   taken;
  logic   load_use;

  // Forwarding select for one source operand. The younger EXE result wins
  // over MEM; register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       use_src,
                                         input trk_t       exe,
                                         input trk_t       mem);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && src != 5'd0) begin
      if (exe.valid && exe.wreg && exe.dest == src)
        sel = 2'b01;
      else if (mem.valid && mem.wreg && mem.dest == src)
        sel = mem.m2reg ? 2'b11 : 2'b10;
    end
    return sel;
  endfunction

  // A branch seen while reset is held must not flush; reset outputs are the
  // plain run-mode defaults.
  assign taken = exe_taken & ~rst;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && exe_q.valid && exe_q.m2reg && exe_q.dest != 5'd0) begin
      load_use = (id_use_rs && id_rs == exe_q.dest) ||
                 (id_use_rt && id_rt == exe_q.dest);
    end

    // Redirect beats load-use: the stalled instruction is on the wrong path.
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    if (taken) begin
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
    end else if (load_use) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idexe_bubble = 1'b1;
    end

    fwda = fwd_sel(id_rs, id_use_rs, exe_q, mem_q);
    fwdb = fwd_sel(id_rt, id_use_rt, exe_q, mem_q);

    // A bubbled or empty slot enters EXE as an invalid entry.
    exe_d = TRK_EMPTY;
    if (id_valid && !idexe_bubble) begin
      exe_d.valid = 1'b1;
      exe_d.wreg  = id_wreg;
      exe_d.m2reg = id_m2reg;
      exe_d.dest  = id_destReg;
    end
    mem_d = exe_q;

    // Next state depends only on this cycle's hazards, so the unused
    // encoding 11 can only ever fall back to RUN.
    if (taken)
      state_d = ST_REDIRECT;
    else if (load_use)
      state_d = ST_STALL;
    else
      state_d = ST_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the tracking registers are reset asynchronously so a stall in
  // progress is abandoned the moment rst rises, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q   <= TRK_EMPTY;
      mem_q   <= TRK_EMPTY;
      state_q <= ST_RUN;
    end else begin
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      state_q <= state_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_d != ST_RUN && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Self-checking bench for hazard_controller (CNT_W = 4). Directed scenarios
// are a table of {ID inputs, expected outputs} rows applied back to back,
// followed by hand-written reset-mid-stall and counter-saturation sequences
// and a randomized run against a pipeline-history model.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt;
  logic             id_use_rs, id_use_rt;
  logic             id_wreg, id_m2reg;
  logic [4:0]       id_destReg;
  logic             exe_taken;
  logic             pc_we, ifid_we, ifid_flush, idexe_bubble;
  logic [1:0]       fwda, fwdb, state;
  logic [CNT_W-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wreg     (id_wreg),
    .id_m2reg    (id_m2reg),
    .id_destReg  (id_destReg),
    .exe_taken   (exe_taken),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idexe_bubble(idexe_bubble),
    .fwda        (fwda),
    .fwdb        (fwdb),
    .state       (state),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a two-entry history of the instructions that left ID
  // (index 0 = now in EXE, index 1 = now in MEM) plus the state and counter.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit valid;
    bit wreg;
    bit m2reg;
    int dest;
  } instr_t;

  instr_t hist[2];
  int     m_state;
  int     m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) hist[i] = '{valid: 0, wreg: 0, m2reg: 0, dest: 0};
    m_state = 0;
    m_cnt   = 0;
  endfunction

  function automatic bit m_load_use();
    int d;
    d = hist[0].dest;
    if (!(id_valid && hist[0].valid && hist[0].m2reg && d != 0)) return 0;
    return (id_use_rs && int'(id_rs) == d) || (id_use_rt && int'(id_rt) == d);
  endfunction

  function automatic int m_fwd(int src, bit use_src);
    if (!use_src || src == 0) return 0;
    if (hist[0].valid && hist[0].wreg && hist[0].dest == src) return 1;
    if (hist[1].valid && hist[1].wreg && hist[1].dest == src) return hist[1].m2reg ? 3 : 2;
    return 0;
  endfunction

  // {pc_we, ifid_we, ifid_flush, idexe_bubble, fwda, fwdb, state}
  function automatic bit [9:0] m_outputs();
    bit lu, tk;
    bit [1:0] fa, fb, st;
    tk = exe_taken;
    lu = m_load_use();
    fa = 2'(m_fwd(int'(id_rs), id_use_rs));
    fb = 2'(m_fwd(int'(id_rt), id_use_rt));
    st = 2'(m_state);
    if (tk)      return {4'b1111, fa, fb, st};
    else if (lu) return {4'b0001, fa, fb, st};
    else         return {4'b1100, fa, fb, st};
  endfunction

  function automatic void model_edge();
    bit lu, bubble;
    int nxt;
    lu     = m_load_use();
    bubble = exe_taken || lu;
    nxt    = exe_taken ? 2 : (lu ? 1 : 0);
    hist[1] = hist[0];
    if (id_valid && !bubble)
      hist[0] = '{valid: 1, wreg: id_wreg, m2reg: id_m2reg, dest: int'(id_destReg)};
    else
      hist[0] = '{valid: 0, wreg: 0, m2reg: 0, dest: 0};
    m_state = nxt;
`ifdef HAZARD_STALL_CNT_EN
    if (nxt != 0 && m_cnt < CNT_MAX) m_cnt++;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_outputs();
    return {pc_we, ifid_we, ifid_flush, idexe_bubble, fwda, fwdb, state};
  endfunction

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input bit m2, input int dst, input bit tk);
    id_valid   = v;
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_use_rs  = urs;
    id_use_rt  = urt;
    id_wreg    = wr;
    id_m2reg   = m2;
    id_destReg = 5'(dst);
    exe_taken  = tk;
  endtask

  // Inputs change just after a falling edge; the model advances on the
  // rising edge using the inputs that the DUT sampled.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  typedef struct {
    string    name;
    bit       v;
    int       rs, rt;
    bit       urs, urt, wr, m2;
    int       dst;
    bit       tk;
    bit [9:0] exp;  // {pc_we, ifid_we, flush, bubble, fwda, fwdb, state}
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(string n, bit v, int rs, int rt, bit urs, bit urt,
                              bit wr, bit m2, int dst, bit tk, bit [9:0] exp);
    vec_t t;
    t.name = n; t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.wr = wr; t.m2 = m2; t.dst = dst; t.tk = tk; t.exp = exp;
    return t;
  endfunction

  initial begin
    bit [9:0] exp_out;

    //                   v  rs  rt urs urt wr m2 dst tk   pc if fl bu fa fb st
    tbl[0]  = mk("lw_r2",       1, 1, 0, 1, 0, 1, 1, 2, 0, 10'b1100_00_00_00);
    tbl[1]  = mk("lu_stall",    1, 2, 5, 1, 1, 1, 0, 7, 0, 10'b0001_01_00_00);
    tbl[2]  = mk("lu_fwd_mdo",  1, 2, 5, 1, 1, 1, 0, 7, 0, 10'b1100_11_00_01);
    tbl[3]  = mk("add_r6",      1, 1, 1, 1, 1, 1, 0, 6, 0, 10'b1100_00_00_00);
    tbl[4]  = mk("sub_fwdb_01", 1, 9, 6, 1, 1, 1, 0, 10, 0, 10'b1100_00_01_00);
    tbl[5]  = mk("or_none",     1, 11, 12, 1, 1, 1, 0, 13, 0, 10'b1100_00_00_00);
    tbl[6]  = mk("add_r6_b",    1, 1, 1, 1, 1, 1, 0, 6, 0, 10'b1100_00_00_00);
    tbl[7]  = mk("xor_gap",     1, 14, 15, 1, 1, 1, 0, 16, 0, 10'b1100_00_00_00);
    tbl[8]  = mk("sub_fwdb_10", 1, 9, 6, 1, 1, 1, 0, 10, 0, 10'b1100_00_10_00);
    tbl[9]  = mk("add_r3_a",    1, 1, 1, 1, 1, 1, 0, 3, 0, 10'b1100_00_00_00);
    tbl[10] = mk("add_r3_b",    1, 1, 1, 1, 1, 1, 0, 3, 0, 10'b1100_00_00_00);
    tbl[11] = mk("exe_over_mem",1, 3, 0, 1, 1, 1, 0, 17, 0, 10'b1100_01_00_00);
    tbl[12] = mk("lw_r0",       1, 1, 0, 1, 0, 1, 1, 0, 0, 10'b1100_00_00_00);
    tbl[13] = mk("r0_no_haz",   1, 0, 0, 1, 1, 1, 0, 5, 0, 10'b1100_00_00_00);
    tbl[14] = mk("lw_r4",       1, 1, 0, 1, 0, 1, 1, 4, 0, 10'b1100_00_00_00);
    tbl[15] = mk("taken_lu",    1, 4, 4, 1, 1, 1, 0, 5, 1, 10'b1111_01_01_00);
    tbl[16] = mk("redirect",    0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1100_00_00_10);
    tbl[17] = mk("back_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b1100_00_00_00);

    // Reset state, with a taken branch on the input to prove it is masked.
    drive(1, 2, 2, 1, 1, 1, 1, 2, 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_outputs", 32'(dut_outputs()), 32'(10'b1100_00_00_00));
    check("reset_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("post_reset_outputs", 32'(dut_outputs()), 32'(10'b1100_00_00_00));
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
            tbl[i].wr, tbl[i].m2, tbl[i].dst, tbl[i].tk);
      #1;
      check(tbl[i].name, 32'(dut_outputs()), 32'(tbl[i].exp));
      step();
    end
    check("table_cnt", 32'(stall_cnt), 32'(m_cnt));

    // Reset asserted in the middle of a stall cycle.
    do_reset();
    drive(1, 1, 0, 1, 0, 1, 1, 2, 0);
    step();
    drive(1, 2, 0, 1, 0, 1, 0, 7, 0);
    #1;
    check("pre_rst_stall", 32'(dut_outputs()), 32'(10'b0001_01_00_00));
    step();
    #1;
    check("stall_state", 32'(state), 32'd1);
    // Keep the offending ID instruction on the inputs through reset.
    drive(1, 2, 0, 1, 0, 1, 0, 7, 0);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_stall_out", 32'(dut_outputs()), 32'(10'b1100_00_00_00));
    check("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_out", 32'(dut_outputs()), 32'(10'b1100_00_00_00));
    step();
    #1;
    check("no_pending_state", 32'(state), 32'd0);

    // Twenty consecutive non-RUN cycles saturate a 4-bit counter.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step();
    #1;
`ifdef HAZARD_STALL_CNT_EN
    check("cnt_saturate", 32'(stall_cnt), 32'(CNT_MAX));
`else
    check("cnt_tied_zero", 32'(stall_cnt), 32'd0);
`endif
    check("cnt_model_20", 32'(stall_cnt), 32'(m_cnt));
    step();
    #1;
    check("cnt_hold", 32'(stall_cnt), 32'(m_cnt));
    check("redirect_hold", 32'(state), 32'd2);

    // Randomized run: small register range so hazards are frequent.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      #1;
      exp_out = m_outputs();
      check($sformatf("rand_out_%0d", i), 32'(dut_outputs()), 32'(exp_out));
      check($sformatf("rand_cnt_%0d", i), 32'(stall_cnt), 32'(m_cnt));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of stall_cnt.
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port id_valid, input, 1: ID stage holds a real instruction.
REQ-005 SHALL have ports id_rs and id_rt, input, 5 each: source register fields in ID.
REQ-006 SHALL have ports id_use_rs and id_use_rt, input, 1 each: the ID instruction reads rs or rt.
REQ-007 SHALL have ports id_wreg and id_m2reg, input, 1 each: ID register-write and load flags.
REQ-008 SHALL have port id_destReg, input, 5: ID destination register.
REQ-009 SHALL have port exe_taken, input, 1: branch in EXE resolved taken this cycle.
REQ-010 SHALL have port pc_we, output, 1: PC write enable.
REQ-011 SHALL have port ifid_we, output, 1: IF/ID write enable.
REQ-012 SHALL have port ifid_flush, output, 1: load NOP into IF/ID.
REQ-013 SHALL have port idexe_bubble, output, 1: force ID/EXE wreg/m2reg/wmem to 0.
REQ-014 SHALL have ports fwda and fwdb, output, 2 each: 00 regfile, 01 EXE r, 10 MEM mr, 11 MEM mdo.
REQ-015 SHALL have port state, output, 2: 00 RUN, 01 STALL, 10 REDIRECT.
REQ-016 SHALL have port stall_cnt, output, CNT_W: count of non-RUN cycles.

Function
REQ-017 SHALL hold internal EXE tracking (valid, wreg, m2reg, dest) loaded each edge from ID inputs, or cleared when idexe_bubble=1 or id_valid=0.
REQ-018 SHALL hold internal MEM tracking registers loaded each edge from the EXE tracking registers.
REQ-019 SHALL set fwda=01 when EXE valid & wreg & dest==id_rs & dest!=0 & id_use_rs, else 10/11 (MEM m2reg 0/1) on the same MEM match, else 00; fwdb likewise with id_rt.
REQ-020 SHALL give EXE match priority over MEM match.
REQ-021 SHALL detect load-use when EXE valid & m2reg & dest!=0 & dest matches a used rs/rt of a valid ID instruction.
REQ-022 SHALL, on load-use without exe_taken, drive pc_we=0, ifid_we=0, idexe_bubble=1, ifid_flush=0 combinationally.
REQ-023 SHALL, on exe_taken, drive pc_we=1, ifid_we=1, ifid_flush=1, idexe_bubble=1, overriding load-use.
REQ-024 SHALL otherwise drive pc_we=1, ifid_we=1, ifid_flush=0, idexe_bubble=0.
REQ-025 SHALL give the state FSM next-state: exe_taken -> REDIRECT; else load-use -> STALL; else RUN; encoding 11 unreachable, recovering to RUN.
REQ-026 SHALL stall exactly one cycle per load-use; the following cycle forwards 11 from MEM.
REQ-027 SHALL never forward or stall on register 0.

Reset
REQ-028 SHALL, while rst=1, clear all tracking valid bits, set state=RUN, stall_cnt=0.
REQ-029 SHALL, during and right after reset, produce pc_we=1, ifid_we=1, ifid_flush=0, idexe_bubble=0, fwda=fwdb=00.
REQ-030 SHALL, when reset asserts mid-stall, immediately abandon the stall, with no pending state on release.

Configuration
REQ-031 SHALL, with macro HAZARD_STALL_CNT_EN defined, increment stall_cnt once per edge where next state is STALL or REDIRECT, saturating at all-ones.
REQ-032 SHALL, without HAZARD_STALL_CNT_EN, keep the stall_cnt port but tie it to 0 and omit the counter.

Verification
REQ-033 SHALL cover: LW r2 in EXE, ID ADD rs=r2 use_rs=1 -> one cycle pc_we=0, ifid_we=0, bubble=1, state=01; next cycle fwda=11, pc_we=1.
REQ-034 SHALL cover: ADD dest r6 in EXE, ID SUB rt=r6 -> fwdb=01, no stall; one cycle later with an unrelated ID instruction in between -> fwdb=10.
REQ-035 SHALL cover: EXE and MEM both write r3, ID rs=r3 -> fwda=01; dest=r0 with rs=r0 -> fwda=00, no stall.
REQ-036 SHALL cover: exe_taken=1 together with a load-use match -> ifid_flush=1, bubble=1, pc_we=1, state=10 next.
REQ-037 SHALL cover: rst pulse during a STALL cycle -> outputs return to defaults at once, and stall_cnt=0.
REQ-038 SHALL cover: with HAZARD_STALL_CNT_EN and CNT_W=4, 20 stall cycles -> stall_cnt=15, held at 15.
